// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access modes, FSM states, lane masks.
// Used by lsu_mem_if and lsu_align.
package lsu_pkg;

   typedef enum logic [2:0] {
      MEM_B    = 3'b000,
      MEM_H    = 3'b001,
      MEM_W    = 3'b010,
      MEM_BU   = 3'b011,
      MEM_HU   = 3'b100,
      MEM_NONE = 3'b111
   } mem_acc_mode_e;

   typedef enum logic [2:0] {
      StIdle,
      StReq0,
      StWait0,
      StReq1,
      StWait1,
      StDone
   } lsu_state_e;

   localparam logic [3:0] LANE_B = 4'b0001;
   localparam logic [3:0] LANE_H = 4'b0011;
   localparam logic [3:0] LANE_W = 4'b1111;

   function automatic logic [3:0] lane_mask(input logic [2:0] mode);
      case (mode)
         MEM_B, MEM_BU: lane_mask = LANE_B;
         MEM_H, MEM_HU: lane_mask = LANE_H;
         default:       lane_mask = LANE_W;
      endcase
   endfunction

   function automatic logic [2:0] acc_size(input logic [2:0] mode);
      case (mode)
         MEM_B, MEM_BU: acc_size = 3'd1;
         MEM_H, MEM_HU: acc_size = 3'd2;
         default:       acc_size = 3'd4;
      endcase
   endfunction

   // True when the access crosses a word boundary and needs a second beat.
   function automatic logic needs_split(input logic [2:0] mode, input logic [1:0] offs);
      needs_split = ({1'b0, offs} + acc_size(mode)) > 3'd4;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane alignment: byte strobes and shifted write data for both
// beats, plus load-data assembly with sign/zero extension.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  mode_i,
   input  logic [1:0]  offs_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] beat0_i,
   input  logic [31:0] beat1_i,
   output logic [3:0]  strb0_o,
   output logic [3:0]  strb1_o,
   output logic [31:0] wdata0_o,
   output logic [31:0] wdata1_o,
   output logic [31:0] ldata_o
);

   logic [5:0]  sh_lo;
   logic [5:0]  sh_hi;
   logic [7:0]  mask8;
   logic [31:0] raw;

   always_comb begin
      sh_lo    = {1'b0, offs_i, 3'b000};
      sh_hi    = 6'd32 - sh_lo;
      // Upper nibble of the shifted mask is exactly the beat-1 strobe.
      mask8    = {4'b0000, lane_mask(mode_i)} << offs_i;
      strb0_o  = mask8[3:0];
      strb1_o  = mask8[7:4];
      wdata0_o = wdata_i << sh_lo;
      wdata1_o = wdata_i >> sh_hi;
      raw      = (beat1_i << sh_hi) | (beat0_i >> sh_lo);
      case (mode_i)
         MEM_B:   ldata_o = {{24{raw[7]}}, raw[7:0]};
         MEM_H:   ldata_o = {{16{raw[15]}}, raw[15:0]};
         MEM_BU:  ldata_o = {24'h000000, raw[7:0]};
         MEM_HU:  ldata_o = {16'h0000, raw[15:0]};
         default: ldata_o = raw;
      endcase
   end

endmodule

// File: rtl/lsu_mem_if.sv
// Load/store unit bus interface: request/grant/response FSM with stall and timeout.
// Define LSU_MISALIGN_SPLIT_EN to split misaligned accesses into two beats.
module lsu_mem_if
   import lsu_pkg::*;
#(
   parameter int unsigned BUS_TIMEOUT = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rd_en,
   input  logic        wr_en,
   input  logic [2:0]  mem_acc_mode,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        stall,
   output logic        bus_err,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_strb,
   output logic [31:0] bus_wdata,
   input  logic        bus_gnt,
   input  logic        bus_rvalid,
   input  logic [31:0] bus_rdata
);

   lsu_state_e  state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [2:0]  mode_q, mode_d;
   logic        we_q, we_d;
   logic        err_q, err_d;
   logic [31:0] beat0_q, beat0_d;
   logic [31:0] beat1_q, beat1_d;
   logic [31:0] cnt_q, cnt_d;

   logic        accept, timeout, stall_c, req_c;
   logic [3:0]  strb0, strb1;
   logic [31:0] wdata0, wdata1, ldata, base;

   lsu_align u_align (
      .mode_i   (mode_q),
      .offs_i   (addr_q[1:0]),
      .wdata_i  (wdata_q),
      .beat0_i  (beat0_q),
      .beat1_i  (beat1_q),
      .strb0_o  (strb0),
      .strb1_o  (strb1),
      .wdata0_o (wdata0),
      .wdata1_o (wdata1),
      .ldata_o  (ldata)
   );

   assign accept  = (rd_en | wr_en) && (mem_acc_mode <= 3'b100);
   assign timeout = (BUS_TIMEOUT != 0) && (cnt_q == BUS_TIMEOUT);

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      mode_d  = mode_q;
      we_d    = we_q;
      err_d   = err_q;
      beat0_d = beat0_q;
      beat1_d = beat1_q;
      stall_c = 1'b0;
      req_c   = 1'b0;
      case (state_q)
         StIdle: begin
            if (accept) begin
               stall_c = 1'b1;
               addr_d  = addr;
               wdata_d = wdata;
               we_d    = wr_en;
               err_d   = 1'b0;
               beat0_d = '0;
               beat1_d = '0;
               mode_d  = mem_acc_mode;
               if (wr_en && mem_acc_mode == MEM_BU) mode_d = MEM_B;
               if (wr_en && mem_acc_mode == MEM_HU) mode_d = MEM_H;
`ifdef LSU_MISALIGN_SPLIT_EN
               state_d = StReq0;
`else
               if (needs_split(mem_acc_mode, addr[1:0])) begin
                  state_d = StDone;
                  err_d   = 1'b1;
               end else begin
                  state_d = StReq0;
               end
`endif
            end
         end
         StReq0: begin
            stall_c = 1'b1;
            if (timeout) begin
               state_d = StDone;
               err_d   = 1'b1;
            end else begin
               req_c = 1'b1;
               if (bus_gnt) begin
`ifdef LSU_MISALIGN_SPLIT_EN
                  if (we_q) state_d = needs_split(mode_q, addr_q[1:0]) ? StReq1 : StDone;
                  else      state_d = StWait0;
`else
                  state_d = we_q ? StDone : StWait0;
`endif
               end
            end
         end
         StWait0: begin
            stall_c = 1'b1;
            if (timeout) begin
               state_d = StDone;
               err_d   = 1'b1;
            end else if (bus_rvalid) begin
               beat0_d = bus_rdata;
`ifdef LSU_MISALIGN_SPLIT_EN
               state_d = needs_split(mode_q, addr_q[1:0]) ? StReq1 : StDone;
`else
               state_d = StDone;
`endif
            end
         end
`ifdef LSU_MISALIGN_SPLIT_EN
         StReq1: begin
            stall_c = 1'b1;
            if (timeout) begin
               state_d = StDone;
               err_d   = 1'b1;
            end else begin
               req_c = 1'b1;
               if (bus_gnt) state_d = we_q ? StDone : StWait1;
            end
         end
         StWait1: begin
            stall_c = 1'b1;
            if (timeout) begin
               state_d = StDone;
               err_d   = 1'b1;
            end else if (bus_rvalid) begin
               beat1_d = bus_rdata;
               state_d = StDone;
            end
         end
`endif
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
      cnt_d = (state_d != state_q) ? '0 : cnt_q + 32'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         addr_q  <= '0;
         wdata_q <= '0;
         mode_q  <= '0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         beat0_q <= '0;
         beat1_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         mode_q  <= mode_d;
         we_q    <= we_d;
         err_q   <= err_d;
         beat0_q <= beat0_d;
         beat1_q <= beat1_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      base      = {addr_q[31:2], 2'b00};
      bus_addr  = '0;
      bus_strb  = '0;
      bus_wdata = '0;
      bus_we    = 1'b0;
      if (state_q == StReq0) begin
         bus_addr  = base;
         bus_strb  = strb0;
         bus_wdata = wdata0;
         bus_we    = we_q;
      end else if (state_q == StReq1) begin
         bus_addr  = base + 32'd4;
         bus_strb  = strb1;
         bus_wdata = wdata1;
         bus_we    = we_q;
      end
   end

   // The accept-cycle stall is combinational from rd_en/wr_en, so mask it in reset.
   assign stall   = stall_c & ~rst;
   assign bus_req = req_c;
   assign bus_err = (state_q == StDone) && err_q;
   assign rdata   = ((state_q == StDone) && !err_q && !we_q) ? ldata : 32'h0;

endmodule

// File: tb/tb_lsu_mem_if.sv
// Directed self-checking bench for lsu_mem_if (BUS_TIMEOUT = 4).
// Follows LSU_MISALIGN_SPLIT_EN to choose split or fault expectations.
module tb_lsu_mem_if;

   logic        clk = 1'b0;
   logic        rst;
   logic        rd_en, wr_en;
   logic [2:0]  mem_acc_mode;
   logic [31:0] addr, wdata;
   logic [31:0] rdata;
   logic        stall, bus_err, bus_req, bus_we;
   logic [31:0] bus_addr, bus_wdata;
   logic [3:0]  bus_strb;
   logic        bus_gnt, bus_rvalid;
   logic [31:0] bus_rdata;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   lsu_mem_if #(.BUS_TIMEOUT(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .rd_en        (rd_en),
      .wr_en        (wr_en),
      .mem_acc_mode (mem_acc_mode),
      .addr         (addr),
      .wdata        (wdata),
      .rdata        (rdata),
      .stall        (stall),
      .bus_err      (bus_err),
      .bus_req      (bus_req),
      .bus_we       (bus_we),
      .bus_addr     (bus_addr),
      .bus_strb     (bus_strb),
      .bus_wdata    (bus_wdata),
      .bus_gnt      (bus_gnt),
      .bus_rvalid   (bus_rvalid),
      .bus_rdata    (bus_rdata)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic go();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic req(input logic rd, input logic wr, input logic [2:0] m,
                      input logic [31:0] a, input logic [31:0] d);
      rd_en = rd; wr_en = wr; mem_acc_mode = m; addr = a; wdata = d;
   endtask

   task automatic bus(input logic g, input logic v, input logic [31:0] d);
      bus_gnt = g; bus_rvalid = v; bus_rdata = d;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      req(1'b1, 1'b0, 3'b010, 32'h0000_0104, 32'h0);
      bus(1'b0, 1'b0, 32'h0);
      smp();
      chk("rst_stall", {31'b0, stall}, 32'd0);
      chk("rst_req", {31'b0, bus_req}, 32'd0);
      chk("rst_we", {31'b0, bus_we}, 32'd0);
      chk("rst_err", {31'b0, bus_err}, 32'd0);
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_addr", bus_addr, 32'h0);
      chk("rst_strb", {28'b0, bus_strb}, 32'h0);
      chk("rst_wdata", bus_wdata, 32'h0);
      go();
      rst = 1'b0;
      req(1'b0, 1'b0, 3'b111, 32'h0, 32'h0);

      // LB at 0x103
      go();
      req(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0);
      smp(); chk("lb_acc_stall", {31'b0, stall}, 32'd1);
      chk("lb_acc_req", {31'b0, bus_req}, 32'd0);
      go(); req(1'b0, 1'b0, 3'b111, 32'h0, 32'h0); bus(1'b1, 1'b0, 32'h0);
      smp(); chk("lb_req", {31'b0, bus_req}, 32'd1);
      chk("lb_addr", bus_addr, 32'h0000_0100);
      chk("lb_strb", {28'b0, bus_strb}, 32'h8);
      chk("lb_we", {31'b0, bus_we}, 32'd0);
      chk("lb_req_stall", {31'b0, stall}, 32'd1);
      go(); bus(1'b0, 1'b1, 32'h80FF_FF00);
      smp(); chk("lb_wait_stall", {31'b0, stall}, 32'd1);
      chk("lb_wait_req", {31'b0, bus_req}, 32'd0);
      go(); bus(1'b0, 1'b0, 32'h0);
      smp(); chk("lb_done_stall", {31'b0, stall}, 32'd0);
      chk("lb_rdata", rdata, 32'hFFFF_FF80);
      chk("lb_err", {31'b0, bus_err}, 32'd0);
      go();
      smp(); chk("lb_idle_rdata", rdata, 32'h0);

      // LHU at 0x102, one cycle without grant and a stray rvalid in REQ0
      go(); req(1'b1, 1'b0, 3'b100, 32'h0000_0102, 32'h0);
      go(); req(1'b0, 1'b0, 3'b111, 32'h0, 32'h0); bus(1'b0, 1'b1, 32'hDEAD_BEEF);
      smp(); chk("lhu_req_hold", {31'b0, bus_req}, 32'd1);
      chk("lhu_strb", {28'b0, bus_strb}, 32'hC);
      go(); bus(1'b1, 1'b0, 32'h0);
      smp(); chk("lhu_addr_stable", bus_addr, 32'h0000_0100);
      chk("lhu_req_gnt", {31'b0, bus_req}, 32'd1);
      go(); bus(1'b0, 1'b1, 32'hABCD_0000);
      go(); bus(1'b0, 1'b0, 32'h0);
      smp(); chk("lhu_rdata", rdata, 32'h0000_ABCD);

      // SW at 0x200
      go(); req(1'b0, 1'b1, 3'b010, 32'h0000_0200, 32'h1122_3344);
      smp(); chk("sw_acc_stall", {31'b0, stall}, 32'd1);
      go(); req(1'b0, 1'b0, 3'b111, 32'h0, 32'h0); bus(1'b1, 1'b0, 32'h0);
      smp(); chk("sw_we", {31'b0, bus_we}, 32'd1);
      chk("sw_strb", {28'b0, bus_strb}, 32'hF);
      chk("sw_wdata", bus_wdata, 32'h1122_3344);
      chk("sw_addr", bus_addr, 32'h0000_0200);
      go(); bus(1'b0, 1'b0, 32'h0);
      smp(); chk("sw_done_stall", {31'b0, stall}, 32'd0);
      chk("sw_done_req", {31'b0, bus_req}, 32'd0);
      chk("sw_done_err", {31'b0, bus_err}, 32'd0);

      // SB via mode 011 at 0x002
      go(); req(1'b0, 1'b1, 3'b011, 32'h0000_0002, 32'h0000_00AB);
      go(); req(1'b0, 1'b0, 3'b111, 32'h0, 32'h0); bus(1'b1, 1'b0, 32'h0);
      smp(); chk("sb_strb", {28'b0, bus_strb}, 32'h4);
      chk("sb_wdata", bus_wdata, 32'h00AB_0000);
      go(); bus(1'b0, 1'b0, 32'h0);
      go();

      // LW at 0x101 (misaligned)
      go(); req(1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0);
      smp(); chk("lwm_acc_stall", {31'b0, stall}, 32'd1);
`ifdef LSU_MISALIGN_SPLIT_EN
      go(); req(1'b0, 1'b0, 3'b111, 32'h0, 32'h0); bus(1'b1, 1'b0, 32'h0);
      smp(); chk("lwm_b0_addr", bus_addr, 32'h0000_0100);
      chk("lwm_b0_strb", {28'b0, bus_strb}, 32'hE);
      go(); bus(1'b0, 1'b1, 32'h4433_2211);
      go(); bus(1'b1, 1'b0, 32'h0);
      smp(); chk("lwm_b1_addr", bus_addr, 32'h0000_0104);
      chk("lwm_b1_strb", {28'b0, bus_strb}, 32'h1);
      chk("lwm_b1_req", {31'b0, bus_req}, 32'd1);
      go(); bus(1'b0, 1'b1, 32'h8877_6655);
      go(); bus(1'b0, 1'b0, 32'h0);
      smp(); chk("lwm_rdata", rdata, 32'h5544_3322);
      chk("lwm_err", {31'b0, bus_err}, 32'd0);
`else
      chk("lwm_acc_req", {31'b0, bus_req}, 32'd0);
      go(); req(1'b0, 1'b0, 3'b111, 32'h0, 32'h0);
      smp(); chk("lwm_err", {31'b0, bus_err}, 32'd1);
      chk("lwm_rdata", rdata, 32'h0);
      chk("lwm_req", {31'b0, bus_req}, 32'd0);
      chk("lwm_done_stall", {31'b0, stall}, 32'd0);
      go();
      smp(); chk("lwm_err_pulse", {31'b0, bus_err}, 32'd0);
`endif
      go();

      // SH 0xBEEF at 0xFFFFFFFF
      go(); req(1'b0, 1'b1, 3'b001, 32'hFFFF_FFFF, 32'h0000_BEEF);
`ifdef LSU_MISALIGN_SPLIT_EN
      go(); req(1'b0, 1'b0, 3'b111, 32'h0, 32'h0); bus(1'b1, 1'b0, 32'h0);
      smp(); chk("sh_b0_addr", bus_addr, 32'hFFFF_FFFC);
      chk("sh_b0_strb", {28'b0, bus_strb}, 32'h8);
      chk("sh_b0_wdata", bus_wdata, 32'hEF00_0000);
      go();
      smp(); chk("sh_b1_addr", bus_addr, 32'h0000_0000);
      chk("sh_b1_strb", {28'b0, bus_strb}, 32'h1);
      chk("sh_b1_wdata", bus_wdata, 32'h0000_00BE);
      chk("sh_b1_we", {31'b0, bus_we}, 32'd1);
      go(); bus(1'b0, 1'b0, 32'h0);
      smp(); chk("sh_done_stall", {31'b0, stall}, 32'd0);
`else
      go(); req(1'b0, 1'b0, 3'b111, 32'h0, 32'h0);
      smp(); chk("sh_err", {31'b0, bus_err}, 32'd1);
      chk("sh_req", {31'b0, bus_req}, 32'd0);
`endif
      go();

      // Timeout: gnt never asserted
      go(); req(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0);
      go(); req(1'b0, 1'b0, 3'b111, 32'h0, 32'h0);
      for (int i = 0; i < 4; i++) begin
         smp(); chk($sformatf("to_req%0d", i), {31'b0, bus_req}, 32'd1);
         go();
      end
      smp(); chk("to_req_drop", {31'b0, bus_req}, 32'd0);
      chk("to_stall", {31'b0, stall}, 32'd1);
      go();
      smp(); chk("to_err", {31'b0, bus_err}, 32'd1);
      chk("to_rdata", rdata, 32'h0);
      chk("to_done_stall", {31'b0, stall}, 32'd0);
      go();
      smp(); chk("to_idle_err", {31'b0, bus_err}, 32'd0);
      chk("to_idle_stall", {31'b0, stall}, 32'd0);

      // Reset while in WAIT0
      go(); req(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0);
      go(); req(1'b0, 1'b0, 3'b111, 32'h0, 32'h0); bus(1'b1, 1'b0, 32'h0);
      go(); bus(1'b0, 1'b0, 32'h0);
      smp(); chk("rw_wait_stall", {31'b0, stall}, 32'd1);
      #1 rst = 1'b1;
      #1 chk("rw_stall", {31'b0, stall}, 32'd0);
      chk("rw_req", {31'b0, bus_req}, 32'd0);
      go(); rst = 1'b0;
      smp(); chk("rw_idle_stall", {31'b0, stall}, 32'd0);
      chk("rw_idle_err", {31'b0, bus_err}, 32'd0);

      // rd_en and wr_en together: store wins
      go(); req(1'b1, 1'b1, 3'b010, 32'h0000_0500, 32'hCAFE_F00D);
      go(); req(1'b0, 1'b0, 3'b111, 32'h0, 32'h0); bus(1'b1, 1'b0, 32'h0);
      smp(); chk("both_we", {31'b0, bus_we}, 32'd1);
      chk("both_wdata", bus_wdata, 32'hCAFE_F00D);
      chk("both_addr", bus_addr, 32'h0000_0500);
      go(); bus(1'b0, 1'b0, 32'h0);
      smp(); chk("both_done_stall", {31'b0, stall}, 32'd0);
      go();

      // Mode 111 and 101 are no-ops
      go(); req(1'b1, 1'b0, 3'b111, 32'h0000_0600, 32'h0);
      smp(); chk("none_stall", {31'b0, stall}, 32'd0);
      go();
      smp(); chk("none_req", {31'b0, bus_req}, 32'd0);
      chk("none_stall2", {31'b0, stall}, 32'd0);
      go(); req(1'b1, 1'b0, 3'b101, 32'h0000_0600, 32'h0);
      smp(); chk("m101_stall", {31'b0, stall}, 32'd0);
      go(); req(1'b0, 1'b0, 3'b111, 32'h0, 32'h0);
      smp(); chk("m101_req", {31'b0, bus_req}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/lsu_mem_if.md
Name: lsu_mem_if

Overview:
Load/store unit directly downstream of the main controller. It consumes rd_en, wr_en and mem_acc_mode, plus the ALU address and rs2 data. It runs a multi-cycle request/grant/response transaction on a 32-bit word-addressed data bus, with byte strobes and a misaligned-access split. It returns sign/zero-extended load data to the writeback MUX and stalls the core while the transaction is in flight.

Parameters:
BUS_TIMEOUT, 0, cycles allowed in any REQ/WAIT state before abort; 0 disables the timeout.

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-high reset
rd_en  in  1  load request from controller
wr_en  in  1  store request from controller
mem_acc_mode  in  3  000 B, 001 H, 010 W, 011 BU, 100 HU, 111 none
addr  in  32  byte address (ALU result)
wdata  in  32  store data (rs2)
rdata  out  32  extended load data; valid in the DONE cycle only
stall  out  1  freezes PC/pipeline while high
bus_err  out  1  one-cycle pulse in DONE after timeout or misalign fault
bus_req  out  1  bus request
bus_we  out  1  1 = write
bus_addr  out  32  word-aligned address, bits [1:0] = 0
bus_strb  out  4  byte-lane enables
bus_wdata  out  32  lane-aligned write data
bus_gnt  in  1  bus accepts the request this cycle
bus_rvalid  in  1  read data valid
bus_rdata  in  32  read data

Behaviour:
- Clock and reset: single clock clk. rst is asynchronous, active-high. During reset: state = IDLE, and rdata, stall, bus_err, bus_req, bus_we, bus_addr, bus_strb, bus_wdata are all 0. Reset mid-transaction abandons it and drops bus_req immediately.
- FSM states: IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE.
- IDLE, accepting a request:
  - Accept when rd_en | wr_en and mode ∈ {000..100}.
  - wr_en has priority when both are high.
  - Capture addr, wdata, mode and direction; go to REQ0.
  - stall = 1 combinationally in the accept cycle.
- IDLE, no-op: enable with mode 101/110/111 is a no-op with stall = 0 and no bus activity.
- Store width: store mode 011/100 is treated as 000/001.
- stall is high in IDLE-accept, REQx and WAITx, and low in DONE and idle.
- REQx:
  - bus_req = 1; addr/we/strb/wdata are held stable until bus_gnt.
  - On gnt, a store goes to the next beat or DONE; a load goes to WAITx.
- WAITx: on bus_rvalid, capture the beat and go to the next beat or DONE. bus_rvalid outside WAITx is ignored.
- DONE: lasts one cycle; rdata is valid and stall = 0; then return to IDLE. The same rd_en seen in DONE is not re-accepted.
- Latency, aligned access with immediate gnt/rvalid: load = 4 cycles (stall 3), store = 3 cycles (stall 2).
- Beat layout, with k = addr[1:0]:
  - Beat0: bus_addr = {addr[31:2],2'b00}; strb = lane mask << k; wdata << 8k.
  - A second beat is needed when k + size > 4 (H at k=3; W at k≠0).
  - Beat1: bus_addr = beat0 address + 4, mod 2^32, so 0xFFFFFFFC wraps to 0x00000000; strb = mask >> (4−k); wdata >> 8(4−k).
  - Lane masks: B 0001, H 0011, W 1111.
- Load assembly: (beat1 << 8(4−k)) | (beat0 >> 8k), truncated to size. Sign-extend for B/H; zero-extend for BU/HU/W.
- Timeout: a counter resets on every state change. When it reaches BUS_TIMEOUT in REQx/WAITx: drop bus_req, go to DONE with bus_err = 1 and rdata = 0.

Optional Feature:
LSU_MISALIGN_SPLIT_EN
- Defined: misaligned accesses are split into two beats as above.
- Undefined: a misaligned access performs no bus access and goes IDLE→DONE, with bus_err = 1 and rdata = 0. REQ1/WAIT1 are not synthesised.

Decomposition:
- Package lsu_pkg:
  - mem_acc_mode_e: MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU, MEM_NONE = 111, shared with the controller.
  - lsu_state_e.
  - Lane-mask constants.
- Sub-module lsu_align: combinational strobe/shift generation and load extension, instantiated once.

Test Plan:
- LB at 0x103, mode 000, bus_rdata 0x80FF_FF00 → bus_strb 1000, rdata 0xFFFF_FF80, stall high 3 cycles.
- LHU at 0x102, rdata 0xABCD_0000 → rdata 0x0000_ABCD. SW 0x1122_3344 at 0x200 → strb 1111, bus_wdata 0x1122_3344, DONE at cycle 2.
- With macro: LW at 0x101, beat0 0x44332211 @0x100, beat1 0x88776655 @0x104 → rdata 0x55443322. Without macro: same stimulus → no bus_req, bus_err pulse, rdata 0.
- SH 0xBEEF at 0xFFFF_FFFF (macro on) → beat0 0xFFFF_FFFC strb 1000 wdata 0xEF00_0000; beat1 0x0000_0000 strb 0001 wdata 0x0000_00BE.
- BUS_TIMEOUT = 4, gnt never asserted → bus_req for 4 cycles, DONE with bus_err = 1, back to IDLE. rst asserted in WAIT0 → bus_req and stall low in the same cycle, state IDLE.
- rd_en = wr_en = 1 mode 010 → store performed. rd_en with mode 111 → stall never asserts, no bus_req.
